// File: rtl/v_wb_pkg.sv
// Shared constants and entry layout for the vector write-back arbiter.
// The mask field exists only when VWB_BYTE_MASK_EN is defined.
package v_wb_pkg;

  localparam int VWB_DW         = 256;
  localparam int VWB_AW         = 5;
  localparam int VWB_NUM_SRC    = 2;
  localparam int VWB_FIFO_DEPTH = 2;
  localparam int VWB_MASK_W     = VWB_DW / 8;

  typedef struct packed {
    logic [VWB_AW-1:0]     addr;
    logic [VWB_DW-1:0]     data;
`ifdef VWB_BYTE_MASK_EN
    logic [VWB_MASK_W-1:0] mask;
`endif
  } v_wb_entry_t;

endpackage

// File: rtl/v_wb_fifo.sv
// Per-source write-back FIFO with a flat tag/valid view of every slot.
// The tag is the top TAG_W bits of each entry (the destination vreg).
module v_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  parameter int TAG_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [W-1:0]           head_o,
  output logic [DEPTH*TAG_W-1:0] ent_o,
  output logic [DEPTH-1:0]       valid_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (PW+1)'(do_push)
                     - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    valid_o = '0;
    ent_o   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_o[i] = {1'b0, PW'(i) - rd_q} < cnt_q;
      ent_o[i*TAG_W +: TAG_W] = mem_q[i][W-1 -: TAG_W];
    end
  end

endmodule

// File: rtl/v_wb_arb.sv
// Vector write-back arbiter: per-source FIFOs, round-robin onto one VRF port.
// Define VWB_BYTE_MASK_EN to carry per-byte write masks with each entry.
module v_wb_arb
  import v_wb_pkg::*;
#(
  parameter int VREG_DW    = VWB_DW,
  parameter int VREG_AW    = VWB_AW,
  parameter int NUM_SRC    = VWB_NUM_SRC,
  parameter int FIFO_DEPTH = VWB_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic [NUM_SRC-1:0]           src_valid_i,
  output logic [NUM_SRC-1:0]           src_ready_o,
  input  logic [NUM_SRC*VREG_AW-1:0]   src_addr_i,
  input  logic [NUM_SRC*VREG_DW-1:0]   src_data_i,
`ifdef VWB_BYTE_MASK_EN
  input  logic [NUM_SRC*(VREG_DW/8)-1:0] src_mask_i,
  output logic [VREG_DW/8-1:0]           vwb_mask_o,
`endif
  output logic                         vwb_en_o,
  output logic [VREG_AW-1:0]           vwb_addr_o,
  output logic [VREG_DW-1:0]           vwb_data_o,
  output logic [$clog2(NUM_SRC):0]     vwb_src_o,
  output logic [2**VREG_AW-1:0]        vwb_pend_o
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int SW = $clog2(NUM_SRC) + 1;
`ifdef VWB_BYTE_MASK_EN
  localparam int MW = VREG_DW / 8;
`endif

  typedef struct packed {
    logic [VREG_AW-1:0] addr;
    logic [VREG_DW-1:0] data;
`ifdef VWB_BYTE_MASK_EN
    logic [MW-1:0]      mask;
`endif
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic [NUM_SRC-1:0]            full;
  logic [NUM_SRC-1:0]            empty;
  logic [NUM_SRC-1:0]            push;
  logic [NUM_SRC-1:0]            pop;
  logic [EW-1:0]                 head [NUM_SRC];
  logic [FIFO_DEPTH*VREG_AW-1:0] tags [NUM_SRC];
  logic [FIFO_DEPTH-1:0]         vld  [NUM_SRC];
  logic [IW-1:0]                 rr_q;
  logic [IW-1:0]                 rr_d;
  logic [IW-1:0]                 win;
  logic                          found;
  logic                          grant;
  logic                          wr_en;
  entry_t                        win_e;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    entry_t in_e;

    always_comb begin
      in_e.addr = src_addr_i[k*VREG_AW +: VREG_AW];
      in_e.data = src_data_i[k*VREG_DW +: VREG_DW];
`ifdef VWB_BYTE_MASK_EN
      in_e.mask = src_mask_i[k*MW +: MW];
`endif
    end

    assign push[k] = src_valid_i[k] & ~full[k] & ~flush_i;
    assign pop[k]  = grant & (win == IW'(k));

    v_wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EW),
      .TAG_W (VREG_AW)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush_i),
      .push_i  (push[k]),
      .din_i   (in_e),
      .pop_i   (pop[k]),
      .full_o  (full[k]),
      .empty_o (empty[k]),
      .head_o  (head[k]),
      .ent_o   (tags[k]),
      .valid_o (vld[k])
    );
  end

  assign src_ready_o = ~full;

  always_comb begin
    found = 1'b0;
    win   = rr_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && !empty[(int'(rr_q) + i) % NUM_SRC]) begin
        found = 1'b1;
        win   = IW'((int'(rr_q) + i) % NUM_SRC);
      end
    end
  end

  assign win_e = entry_t'(head[win]);
  assign grant = found & ~flush_i;

  // A zero-mask entry still pops and moves the pointer, but never writes.
`ifdef VWB_BYTE_MASK_EN
  assign wr_en      = grant & (|win_e.mask);
  assign vwb_mask_o = wr_en ? win_e.mask : '0;
`else
  assign wr_en = grant;
`endif

  assign vwb_en_o   = wr_en;
  assign vwb_addr_o = wr_en ? win_e.addr : '0;
  assign vwb_data_o = wr_en ? win_e.data : '0;
  assign vwb_src_o  = wr_en ? SW'(win) : '0;

  always_comb begin
    rr_d = rr_q;
    if (grant) begin
      if (int'(win) == NUM_SRC - 1) rr_d = '0;
      else                          rr_d = win + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end

  always_comb begin
    vwb_pend_o = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int d = 0; d < FIFO_DEPTH; d++) begin
        if (vld[k][d])
          vwb_pend_o[tags[k][d*VREG_AW +: VREG_AW]] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_v_wb_arb.sv
// Directed bench for v_wb_arb (NUM_SRC=2, FIFO_DEPTH=2, 256-bit data).
// Mask checks compile in when VWB_BYTE_MASK_EN is defined.
module tb_v_wb_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [1:0]   src_valid;
  logic [1:0]   src_ready;
  logic [9:0]   src_addr;
  logic [511:0] src_data;
  logic         en;
  logic [4:0]   waddr;
  logic [255:0] wdata;
  logic [1:0]   wsrc;
  logic [31:0]  pend;
`ifdef VWB_BYTE_MASK_EN
  logic [63:0]  src_mask;
  logic [31:0]  wmask;
`endif

  int tests = 0;
  int fails = 0;
  int n0, n1, w, first, last;
  logic [1:0] rdy;
  int exp_s [6] = '{0, 1, 0, 1, 0, 1};
  int exp_j [6] = '{0, 0, 1, 1, 2, 2};

  v_wb_arb dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .src_valid_i (src_valid),
    .src_ready_o (src_ready),
    .src_addr_i  (src_addr),
    .src_data_i  (src_data),
`ifdef VWB_BYTE_MASK_EN
    .src_mask_i  (src_mask),
    .vwb_mask_o  (wmask),
`endif
    .vwb_en_o    (en),
    .vwb_addr_o  (waddr),
    .vwb_data_o  (wdata),
    .vwb_src_o   (wsrc),
    .vwb_pend_o  (pend)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] dv(input int s,
                                      input int j);
    logic [7:0] a;
    logic [7:0] b;
    a = s[7:0];
    b = j[7:0];
    return {8{a, b, 16'hC0DE}};
  endfunction

  task automatic setsrc(input int s,
                        input logic [4:0] a,
                        input logic [255:0] d);
    src_addr[s*5 +: 5]     = a;
    src_data[s*256 +: 256] = d;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
`ifdef VWB_BYTE_MASK_EN
    src_mask  = '1;
`endif
    tick();
    tick();
    chk("rst_en", en, 0);
    chk("rst_addr", waddr, 0);
    chk("rst_data", wdata, 0);
    chk("rst_src", wsrc, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ready", src_ready, 2'b11);
    rst = 1'b0;

    // single push, visible the next cycle
    src_valid = 2'b01;
    setsrc(0, 5'd3, dv(0, 15));
    chk("t1_no_bypass", en, 0);
    tick();
    src_valid = '0;
    chk("t1_en", en, 1);
    chk("t1_addr", waddr, 3);
    chk("t1_data", wdata, dv(0, 15));
    chk("t1_src", wsrc, 0);
    chk("t1_pend", pend, 32'h8);
    tick();
    chk("t1_idle_en", en, 0);
    chk("t1_idle_data", wdata, 0);
    chk("t1_idle_pend", pend, 0);

    // contention, rr restarts at 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n0 = 0; n1 = 0; w = 0;
    first = -1; last = -1;
    for (int c = 0; c < 10; c++) begin
      src_valid = {n1 < 3, n0 < 3};
      setsrc(0, 5'd1, dv(0, n0));
      setsrc(1, 5'd2, dv(1, n1));
      rdy = src_ready;
      tick();
      if (src_valid[0] && rdy[0]) n0++;
      if (src_valid[1] && rdy[1]) n1++;
      if (en) begin
        if (w < 6) begin
          chk("t2_src", wsrc, exp_s[w]);
          chk("t2_addr", waddr, exp_s[w] + 1);
          chk("t2_data", wdata, dv(exp_s[w], exp_j[w]));
        end
        if (first < 0) first = c;
        last = c;
        w++;
      end
    end
    src_valid = '0;
    chk("t2_writes", w, 6);
    chk("t2_span", last - first, 5);

    // full FIFO on src0 while src1 takes alternate grants
    src_valid = 2'b01;
    setsrc(0, 5'd4, dv(2, 0));
    tick();
    src_valid = 2'b11;
    setsrc(0, 5'd4, dv(2, 1));
    setsrc(1, 5'd6, dv(3, 0));
    tick();
    chk("t3_c1_src", wsrc, 1);
    chk("t3_c1_data", wdata, dv(3, 0));
    chk("t3_c1_ready", src_ready, 2'b11);
    setsrc(0, 5'd4, dv(2, 2));
    setsrc(1, 5'd6, dv(3, 1));
    tick();
    chk("t3_full_ready", src_ready, 2'b10);
    chk("t3_c2_data", wdata, dv(2, 1));
    chk("t3_c2_pend", pend, 32'h50);
    src_valid = 2'b01;
    setsrc(0, 5'd4, dv(2, 3));
    tick();
    chk("t3_c3_ready", src_ready, 2'b11);
    chk("t3_c3_data", wdata, dv(3, 1));
    tick();
    src_valid = '0;
    chk("t3_c4_data", wdata, dv(2, 2));
    chk("t3_c4_ready", src_ready, 2'b10);
    tick();
    chk("t3_c5_data", wdata, dv(2, 3));
    tick();
    chk("t3_c6_en", en, 0);

    // pending bit survives until the second write to vreg 5
    src_valid = 2'b11;
    setsrc(0, 5'd5, dv(4, 0));
    setsrc(1, 5'd5, dv(5, 0));
    tick();
    src_valid = '0;
    chk("t4_c1_src", wsrc, 1);
    chk("t4_c1_pend", pend, 32'h20);
    tick();
    chk("t4_c2_src", wsrc, 0);
    chk("t4_c2_pend", pend, 32'h20);
    tick();
    chk("t4_c3_pend", pend, 0);
    chk("t4_c3_en", en, 0);

    // flush with a simultaneous push
    src_valid = 2'b11;
    setsrc(0, 5'd7, dv(6, 0));
    setsrc(1, 5'd8, dv(7, 0));
    tick();
    chk("t5_pend", pend, 32'h180);
    flush = 1'b1;
    setsrc(0, 5'd9, dv(6, 1));
    setsrc(1, 5'd10, dv(7, 1));
    #1;
    chk("t5_flush_en", en, 0);
    chk("t5_flush_addr", waddr, 0);
    tick();
    flush = 1'b0;
    src_valid = '0;
    chk("t5_post_en", en, 0);
    chk("t5_post_pend", pend, 0);
    chk("t5_post_ready", src_ready, 2'b11);
    src_valid = 2'b11;
    setsrc(0, 5'd9, dv(8, 0));
    setsrc(1, 5'd10, dv(9, 0));
    tick();
    src_valid = '0;
    chk("t5_rr_src", wsrc, 1);
    chk("t5_rr_addr", waddr, 10);
    tick();
    chk("t5_next_addr", waddr, 9);
    tick();

    // reset mid-stream
    src_valid = 2'b11;
    tick();
    src_valid = '0;
    chk("t6_pre_en", en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_en", en, 0);
    chk("t6_pend", pend, 0);
    chk("t6_ready", src_ready, 2'b11);

`ifdef VWB_BYTE_MASK_EN
    src_valid = 2'b11;
    src_mask  = {32'h0000_00FF, 32'h0};
    setsrc(0, 5'd11, dv(10, 0));
    setsrc(1, 5'd12, dv(11, 0));
    tick();
    src_valid = '0;
    src_mask  = '1;
    chk("t7_drop_en", en, 0);
    chk("t7_drop_mask", wmask, 0);
    tick();
    chk("t7_en", en, 1);
    chk("t7_src", wsrc, 1);
    chk("t7_addr", waddr, 12);
    chk("t7_mask", wmask, 32'hFF);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
